// File: rtl/chip_pkg.sv
// Shared constants for the NAND-latch chip stimulus driver.
package chip_pkg;

  // Driver FSM state encoding
  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_DRIVE  = 3'd1;
  localparam logic [2:0] ST_SETTLE = 3'd2;
  localparam logic [2:0] ST_SAMPLE = 3'd3;
  localparam logic [2:0] ST_RESP   = 3'd4;

  // Chip pin levels that keep the latch closed
  localparam logic CHIP_G_IDLE    = 1'b0;
  localparam logic CHIP_NOTE_IDLE = 1'b1;

endpackage : chip_pkg

// File: rtl/chip_sync1.sv
// Multi-stage 1-bit synchronizer for the asynchronous chip output.
module chip_sync1 #(
  parameter int unsigned STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] stg;

  // Shift the asynchronous input through the flop chain
  always_ff @(posedge clk) begin
    if (rst) begin
      stg <= '0;
    end else begin
      stg <= {stg[STAGES-2:0], d};
    end
  end

  assign q = stg[STAGES-1];

endmodule : chip_sync1

// File: rtl/chip_stim_driver.sv
// Drives one {G,notE} vector onto the NAND-latch chip, waits for it to
// settle, samples Y through a synchronizer and returns it with a check flag.
module chip_stim_driver #(
  parameter int unsigned SETTLE_CYC  = 4,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic             req_g,
  input  logic             req_note,
  input  logic             req_exp,
  input  logic             req_chk,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_y,
  output logic             rsp_err,
  output logic             chip_g,
  output logic             chip_note,
  input  logic             chip_y,
  output logic [CNT_W-1:0] vec_cnt,
  output logic [CNT_W-1:0] err_cnt
);

  import chip_pkg::*;

  localparam int unsigned TMR_MAX = (SETTLE_CYC > SYNC_STAGES) ? SETTLE_CYC : SYNC_STAGES;
  localparam int unsigned TMR_W   = $clog2(TMR_MAX + 1);

  logic [2:0]       state;
  logic [2:0]       nextState;
  logic [TMR_W-1:0] tmr;
  logic             latExp;
  logic             latChk;
  logic             syncY;

  chip_sync1 #(
    .STAGES(SYNC_STAGES)
  ) uSync (
    .clk(clk),
    .rst(rst),
    .d  (chip_y),
    .q  (syncY)
  );

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= nextState;
    end
  end

  // Next-state decode
  always_comb begin
    nextState = state;
    case (state)
      ST_IDLE:   if (req_valid) nextState = ST_DRIVE;
      ST_DRIVE:  nextState = ST_SETTLE;
      ST_SETTLE: if (tmr == '0) nextState = ST_SAMPLE;
      ST_SAMPLE: if (tmr == '0) nextState = ST_RESP;
      ST_RESP:   if (rsp_ready) nextState = ST_IDLE;
      default:   nextState = ST_IDLE;
    endcase
  end

  // Datapath: chip pins, phase timer, response and counters.
  // Chip pins load at acceptance so they change during the DRIVE cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      req_ready <= 1'b1;
      chip_g    <= CHIP_G_IDLE;
      chip_note <= CHIP_NOTE_IDLE;
      latExp    <= 1'b0;
      latChk    <= 1'b0;
      tmr       <= '0;
      rsp_valid <= 1'b0;
      rsp_y     <= 1'b0;
      rsp_err   <= 1'b0;
      vec_cnt   <= '0;
      err_cnt   <= '0;
    end else begin
      req_ready <= (nextState == ST_IDLE);
      case (state)
        ST_IDLE: begin
          if (req_valid) begin
            chip_g    <= req_g;
            chip_note <= req_note;
            latExp    <= req_exp;
            latChk    <= req_chk;
          end
        end
        ST_DRIVE: begin
          tmr <= TMR_W'(SETTLE_CYC - 1);
        end
        ST_SETTLE: begin
          if (tmr == '0) begin
            tmr <= TMR_W'(SYNC_STAGES - 1);
          end else begin
            tmr <= tmr - TMR_W'(1);
          end
        end
        ST_SAMPLE: begin
          if (tmr == '0) begin
            rsp_y     <= syncY;
            rsp_err   <= latChk & (syncY != latExp);
            rsp_valid <= 1'b1;
          end else begin
            tmr <= tmr - TMR_W'(1);
          end
        end
        ST_RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            rsp_err   <= 1'b0;
            vec_cnt   <= vec_cnt + CNT_W'(1);
            if (rsp_err && (err_cnt != '1)) begin
              err_cnt <= err_cnt + CNT_W'(1);
            end
          end
        end
        default: begin
          tmr <= '0;
        end
      endcase
    end
  end

endmodule : chip_stim_driver

// File: tb/tb_chip_stim_driver.sv
// Bench for chip_stim_driver with a gate-level NAND latch chip model.
// Counters are built narrow so saturation and wrap are reachable quickly.
module tb_chip_stim_driver;

  localparam int unsigned BCNT_W = 4;

  typedef struct packed {
    logic y;
    logic err;
  } rspExp_t;

  logic              clk = 1'b0;
  logic              rst;
  logic              req_valid, req_ready, req_g, req_note, req_exp, req_chk;
  logic              rsp_valid, rsp_ready, rsp_y, rsp_err;
  logic              chip_g, chip_note;
  logic [BCNT_W-1:0] vec_cnt, err_cnt;

  // chip model nets: gated SR latch from 1 ns NAND gates
  logic gN = 1'b1, sN = 1'b1, rN = 1'b1, modelY = 1'b0, modelYn = 1'b1;
  wire  gIn = (chip_g === 1'b1);
  wire  eIn = (chip_note === 1'b0);

  always @(gIn)            gN      <= #1 ~(gIn & gIn);
  always @(gIn or eIn)     sN      <= #1 ~(gIn & eIn);
  always @(gN or eIn)      rN      <= #1 ~(gN & eIn);
  always @(sN or modelYn)  modelY  <= #1 ~(sN & modelYn);
  always @(rN or modelY)   modelYn <= #1 ~(rN & modelY);

  always #5 clk = ~clk;

  chip_stim_driver #(
    .SETTLE_CYC (4),
    .SYNC_STAGES(2),
    .CNT_W      (BCNT_W)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_g    (req_g),
    .req_note (req_note),
    .req_exp  (req_exp),
    .req_chk  (req_chk),
    .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready),
    .rsp_y    (rsp_y),
    .rsp_err  (rsp_err),
    .chip_g   (chip_g),
    .chip_note(chip_note),
    .chip_y   (modelY),
    .vec_cnt  (vec_cnt),
    .err_cnt  (err_cnt)
  );

  int                totalCnt = 0;
  int                badCnt   = 0;
  rspExp_t           sb[$];
  logic              refLatch = 1'b0;
  logic [BCNT_W-1:0] expVec = '0;
  logic [BCNT_W-1:0] expErr = '0;
  bit                pendingCnt = 1'b0;

  task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] want);
    totalCnt++;
    if (got !== want) begin
      badCnt++;
      $display("FAIL %s: got=%0h want=%0h @%0t", tag, got, want, $time);
    end
  endtask

  // Reference Y for a vector: latch follows G while notE is low, else holds
  function automatic logic refY(input logic g, input logic note);
    return (note == 1'b0) ? g : refLatch;
  endfunction

  // Present one request and push its expected response once accepted
  task automatic sendVec(input logic g, input logic note, input logic ex, input logic chk);
    rspExp_t e;
    int n = 0;
    @(negedge clk);
    while (!req_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!req_ready) checkVal("reqReadyTimeout", req_ready, 1);
    req_g = g; req_note = note; req_exp = ex; req_chk = chk; req_valid = 1'b1;
    @(posedge clk);
    #1 req_valid = 1'b0;
    e.y      = refY(g, note);
    e.err    = chk & (e.y != ex);
    refLatch = e.y;
    sb.push_back(e);
  endtask

  // Count negedges from acceptance until rsp_valid is seen
  task automatic waitValid(output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!rsp_valid && n < 40);
    if (!rsp_valid) checkVal("rspTimeout", rsp_valid, 1);
  endtask

  task automatic drain();
    int n = 0;
    while ((sb.size() != 0 || pendingCnt) && n < 60) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0) checkVal("drain", sb.size(), 0);
    @(negedge clk);
  endtask

  // Scoreboard monitor: compare responses on handshake, counters one cycle later
  always @(negedge clk) begin
    rspExp_t e;
    if (pendingCnt) begin
      checkVal("vecCnt", vec_cnt, expVec);
      checkVal("errCnt", err_cnt, expErr);
      pendingCnt = 1'b0;
    end
    if (!rst && rsp_valid && rsp_ready) begin
      if (sb.size() == 0) begin
        checkVal("unexpectedRsp", sb.size(), 1);
      end else begin
        e = sb.pop_front();
        checkVal("rspY", rsp_y, e.y);
        checkVal("rspErr", rsp_err, e.err);
        expVec = expVec + 1'b1;
        if (e.err && expErr != '1) expErr = expErr + 1'b1;
        pendingCnt = 1'b1;
      end
    end
  end

  initial begin
    int  n;
    bit  sawRsp;
    rst = 1'b1; req_valid = 1'b0; req_g = 1'b0; req_note = 1'b1;
    req_exp = 1'b0; req_chk = 1'b0; rsp_ready = 1'b1;

    // reset values
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkVal("rstChipG", chip_g, 0);
    checkVal("rstChipNote", chip_note, 1);
    checkVal("rstRspValid", rsp_valid, 0);
    checkVal("rstVecCnt", vec_cnt, 0);
    checkVal("rstErrCnt", err_cnt, 0);
    checkVal("rstReqReady", req_ready, 1);
    rst = 1'b0;

    // basic vector, latency and pin timing
    sendVec(1'b1, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    checkVal("pinG", chip_g, 1);
    checkVal("pinNote", chip_note, 0);
    checkVal("busyReady", req_ready, 0);
    n = 1;
    while (!rsp_valid && n < 40) begin
      @(negedge clk);
      n++;
    end
    checkVal("latency", n, 8);
    drain();

    // checked vector, wrong then right expectation
    sendVec(1'b0, 1'b0, 1'b1, 1'b1);
    waitValid(n);
    @(negedge clk);
    checkVal("errPulse", rsp_err, 0);
    drain();
    sendVec(1'b1, 1'b0, 1'b1, 1'b1);
    drain();
    checkVal("errHold", err_cnt, 1);

    // closed latch holds previous value; unchecked mismatch does not count
    sendVec(1'b0, 1'b1, 1'b0, 1'b0);
    drain();

    // stall with rsp_ready low
    rsp_ready = 1'b0;
    sendVec(1'b0, 1'b1, 1'b0, 1'b1);
    waitValid(n);
    for (int i = 0; i < 20; i++) begin
      checkVal("stallValid", rsp_valid, 1);
      checkVal("stallY", rsp_y, sb[0].y);
      checkVal("stallErr", rsp_err, sb[0].err);
      checkVal("stallReady", req_ready, 0);
      checkVal("stallVec", vec_cnt, expVec);
      @(negedge clk);
    end
    @(posedge clk);
    #1 rsp_ready = 1'b1;
    drain();

    // reset during SETTLE
    sendVec(1'b0, 1'b0, 1'b0, 1'b1);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    sb.delete();
    expVec = '0; expErr = '0; pendingCnt = 1'b0;
    checkVal("midRstReady", req_ready, 1);
    checkVal("midRstNote", chip_note, 1);
    checkVal("midRstG", chip_g, 0);
    checkVal("midRstVec", vec_cnt, 0);
    sawRsp = 1'b0;
    repeat (15) begin
      @(negedge clk);
      if (rsp_valid) sawRsp = 1'b1;
    end
    checkVal("midRstNoRsp", sawRsp, 0);

    // saturate err_cnt, wrap vec_cnt
    for (int i = 0; i < 15; i++) begin
      logic g;
      g = 1'(i & 1);
      sendVec(g, 1'b0, ~g, 1'b1);
      drain();
    end
    checkVal("preWrapVec", vec_cnt, 15);
    checkVal("preSatErr", err_cnt, 15);
    sendVec(1'b1, 1'b0, 1'b0, 1'b1);
    drain();
    checkVal("errSat", err_cnt, 15);
    checkVal("vecWrap", vec_cnt, 0);

    $display("test done: total=%0d bad=%0d", totalCnt, badCnt);
    $finish;
  end

endmodule : tb_chip_stim_driver
